mux_scan: RTL and testbench
===========================

# mux_scan

Parametrised, registered N-to-1 multiplexer with a valid/ready output stage and an autonomous scan mode. In direct mode it behaves like the existing combinational multiplexers with one cycle of latency. In scan mode an internal pointer walks through the channels enabled by a mask and emits one sample per accepted transfer, tagged with the channel index and a last-of-sweep flag. It sits between multi-channel sources and a single-lane consumer such as a serialiser or logger.

## Interface
Parameters:
- CHANNELS, 16: number of input channels; legal range 2..256.
- WIDTH, 1: bits per channel.
- SEL_W, clog2(CHANNELS): derived localparam; width of select and index fields.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- A  in  CHANNELS*WIDTH  packed channel data; channel i occupies A[i*WIDTH +: WIDTH].
- enable  in  1  when 0, no new sample is captured.
- mode  in  1  0 = direct (uses sel), 1 = scan (uses mask and the internal pointer).
- sel  in  SEL_W  direct-mode channel select.
- mask  in  CHANNELS  scan-mode channel enables; bit i = 1 includes channel i.
- Y  out  WIDTH  registered sample.
- y_ch  out  SEL_W  channel index of Y.
- y_last  out  1  scan mode: Y is from the highest-index set bit of mask. Always 0 in direct mode.
- y_valid  out  1  Y, y_ch and y_last are valid.
- y_ready  in  1  consumer accepts the current output.

## Operation
- Output register: a single stage. load = enable & (~y_valid | y_ready).
- Capture:
  - On load with a channel available, write Y, y_ch and y_last, and set y_valid = 1.
  - If y_valid & y_ready and there is no capture, clear y_valid.
  - Otherwise hold all outputs. Held outputs stay stable while y_valid & ~y_ready.
- Direct mode:
  - A channel is always available.
  - Y = channel sel, y_ch = sel, y_last = 0.
  - If sel >= CHANNELS, Y = 0 and y_ch = sel; the sample is still valid.
- Scan mode, internal pointer ptr (SEL_W bits):
  - The candidate is the lowest set mask bit at index >= ptr. If there is none, it is the lowest set mask bit overall (wrap-around).
  - On capture: ptr <= candidate + 1, wrapping to 0 when candidate = CHANNELS-1.
  - y_last = 1 when the candidate is the highest set mask bit.
  - If mask = 0, no channel is available, so no capture and ptr holds.
  - Mask is sampled on the capture cycle. A mask change mid-sweep takes effect at the next capture; no restart.
- Mode switch:
  - When mode differs from its value registered on the previous cycle, ptr <= 0 and no capture occurs that cycle.
  - The pending output is unaffected.
- enable = 0:
  - No capture; ptr holds.
  - A pending output is still delivered and then y_valid clears.
- Control state, two states:
  - IDLE: y_valid = 0. Moves to FULL on capture.
  - FULL: y_valid = 1. Stays on hold or on capture with handshake. Moves to IDLE on handshake without capture.

## Timing
- Reset values: Y = 0, y_ch = 0, y_last = 0, y_valid = 0, ptr = 0, registered mode = 0.
- Reset mid-transfer discards the pending sample; y_valid is 0 on the cycle after reset is sampled.
- Latency is 1 cycle from A/sel sampled at the capture edge to Y.
- Throughput is one sample per cycle when y_ready is held at 1.
- A simultaneous handshake and capture in the same cycle is legal: the new sample replaces the old with no bubble.
- y_ready may be asserted while y_valid = 0; it has no effect.
- There is no combinational path from A, sel, mask or y_ready to any output.

## Test plan
- Direct sweep: CHANNELS=16, WIDTH=8, A[i] = 8'h10+i, mode=0, y_ready=1, sel = 0..15 on consecutive cycles -> Y = 8'h10..8'h1F one cycle later, y_ch = sel, y_valid held at 1, y_last = 0.
- Scan with mask: mask = 16'h8421, mode=1, y_ready=1 -> y_ch sequence 0, 5, 10, 15, 0, ... with y_last = 1 only at y_ch = 15.
- Back-pressure: mode=1, mask = 16'h000F, y_ready low for 3 cycles after the first sample -> Y and y_ch = 0 held stable for 3 cycles; after y_ready rises, y_ch = 1 with no channel skipped.
- Empty mask and enable: mask = 0 -> y_valid stays 0 and ptr stays 0. Then mask = 16'h0010 -> y_ch = 4 with y_last = 1 every cycle. Drop enable with y_ready=1 -> y_valid clears after one cycle.
- Mode switch and reset:
  - In scan mode at ptr = 6, switch to mode=0 then back to 1 -> the first scan capture after return restarts from channel 0 (lowest set bit).
  - Assert rst while y_valid = 1 and y_ready = 0 -> the next cycle shows all outputs at 0.
- Non-power-of-two: CHANNELS=5, direct sel=7 -> Y = 0, y_ch = 7, valid. Scan with mask = 5'b10011 -> y_ch sequence 0, 1, 4, 0.

Source files
------------

// File: rtl/mux_scan.sv
// Registered N-to-1 multiplexer with a valid/ready output stage.
// Direct mode selects by sel; scan mode walks the channels enabled by mask.
module mux_scan #(
  parameter int CHANNELS = 16,
  parameter int WIDTH = 1,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] A,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       mask,
  output logic [WIDTH-1:0]          Y,
  output logic [SEL_W-1:0]          y_ch,
  output logic                      y_last,
  output logic                      y_valid,
  input  logic                      y_ready
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t             state_r, state_nx_s;
  logic               mode_r;
  logic [SEL_W-1:0]   ptr_r;
  logic [SEL_W-1:0]   lo_s, hi_s, top_s, cand_s, pick_s, ptr_nx_s;
  logic               lo_found_s, hi_found_s;
  logic               avail_s, mode_sw_s, load_s, capture_s;
  logic [WIDTH-1:0]   data_s;

  // Scan candidate: first set bit at or above ptr, else wrap to the lowest set bit.
  always_comb begin
    lo_s       = {SEL_W{1'b0}};
    hi_s       = {SEL_W{1'b0}};
    top_s      = {SEL_W{1'b0}};
    lo_found_s = 1'b0;
    hi_found_s = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (mask[i]) begin
        if (!lo_found_s) begin
          lo_s       = SEL_W'(i);
          lo_found_s = 1'b1;
        end else begin
          lo_s = lo_s;
        end
        if (!hi_found_s && (i >= int'(ptr_r))) begin
          hi_s       = SEL_W'(i);
          hi_found_s = 1'b1;
        end else begin
          hi_s = hi_s;
        end
        top_s = SEL_W'(i);
      end else begin
        top_s = top_s;
      end
    end
    cand_s   = hi_found_s ? hi_s : lo_s;
    ptr_nx_s = (cand_s == SEL_W'(CHANNELS - 1)) ? {SEL_W{1'b0}} : cand_s + SEL_W'(1);
  end

  // Channel data mux; an out-of-range index yields zero.
  always_comb begin
    pick_s = mode ? cand_s : sel;
    data_s = {WIDTH{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (pick_s == SEL_W'(i)) begin
        data_s = A[i*WIDTH +: WIDTH];
      end else begin
        data_s = data_s;
      end
    end
  end

  // Capture qualification and output-stage next state.
  always_comb begin
    mode_sw_s  = (mode != mode_r);
    avail_s    = ~mode | (|mask);
    load_s     = enable & (~y_valid | y_ready);
    capture_s  = load_s & avail_s & ~mode_sw_s;
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (capture_s) state_nx_s = FULL;
        else           state_nx_s = IDLE;
      end
      FULL: begin
        if (capture_s)    state_nx_s = FULL;
        else if (y_ready) state_nx_s = IDLE;
        else              state_nx_s = FULL;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  assign y_valid = (state_r == FULL);

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      mode_r  <= 1'b0;
      ptr_r   <= {SEL_W{1'b0}};
      Y       <= {WIDTH{1'b0}};
      y_ch    <= {SEL_W{1'b0}};
      y_last  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      mode_r  <= mode;
      if (mode_sw_s) begin
        ptr_r <= {SEL_W{1'b0}};
      end else if (capture_s && mode) begin
        ptr_r <= ptr_nx_s;
      end else begin
        ptr_r <= ptr_r;
      end
      if (capture_s) begin
        Y      <= data_s;
        y_ch   <= pick_s;
        y_last <= mode & (cand_s == top_s);
      end else begin
        Y      <= Y;
        y_ch   <= y_ch;
        y_last <= y_last;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: a 16x8 instance and a 5x8 instance.
module tb_mux_scan;

  typedef struct packed {
    logic [7:0] y;
    logic [3:0] ch;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16-channel instance
  logic [127:0] a16;
  logic         en16, mode16, ready16;
  logic [3:0]   sel16;
  logic [15:0]  mask16;
  logic [7:0]   y16;
  logic [3:0]   ch16;
  logic         last16, valid16;

  // 5-channel instance
  logic [39:0]  a5;
  logic         en5, mode5, ready5;
  logic [2:0]   sel5;
  logic [4:0]   mask5;
  logic [7:0]   y5;
  logic [2:0]   ch5;
  logic         last5, valid5;

  int checks = 0;
  int errors = 0;
  exp_t q16[$];
  exp_t q5[$];

  mux_scan #(.CHANNELS(16), .WIDTH(8)) dut16 (
    .clk(clk), .rst(rst), .A(a16), .enable(en16), .mode(mode16), .sel(sel16),
    .mask(mask16), .Y(y16), .y_ch(ch16), .y_last(last16), .y_valid(valid16),
    .y_ready(ready16)
  );

  mux_scan #(.CHANNELS(5), .WIDTH(8)) dut5 (
    .clk(clk), .rst(rst), .A(a5), .enable(en5), .mode(mode5), .sel(sel5),
    .mask(mask5), .Y(y5), .y_ch(ch5), .y_last(last5), .y_valid(valid5),
    .y_ready(ready5)
  );

  function automatic exp_t mk(input logic [7:0] y, input logic [3:0] ch, input logic last);
    exp_t e;
    e.y = y; e.ch = ch; e.last = last;
    return e;
  endfunction

  // Monitor for the 16-channel instance: every transfer pops one expectation.
  always @(negedge clk) begin
    if (valid16 && ready16) begin
      exp_t e;
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL dut16_unexpected got Y=%h ch=%0d last=%0d, no sample expected", y16, ch16, last16);
      end else begin
        e = q16.pop_front();
        if (y16 !== e.y || ch16 !== e.ch || last16 !== e.last) begin
          errors++;
          $display("FAIL dut16_sample got Y=%h ch=%0d last=%0d expected Y=%h ch=%0d last=%0d",
                   y16, ch16, last16, e.y, e.ch, e.last);
        end
      end
    end
  end

  // Monitor for the 5-channel instance.
  always @(negedge clk) begin
    if (valid5 && ready5) begin
      exp_t e;
      checks++;
      if (q5.size() == 0) begin
        errors++;
        $display("FAIL dut5_unexpected got Y=%h ch=%0d last=%0d, no sample expected", y5, ch5, last5);
      end else begin
        e = q5.pop_front();
        if (y5 !== e.y || {1'b0, ch5} !== e.ch || last5 !== e.last) begin
          errors++;
          $display("FAIL dut5_sample got Y=%h ch=%0d last=%0d expected Y=%h ch=%0d last=%0d",
                   y5, ch5, last5, e.y, e.ch, e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic toggle_mode16();
    en16 = 1'b0;
    mode16 = 1'b0;
    tick();
    mode16 = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) a16[i*8 +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < 5; i++)  a5[i*8 +: 8]  = 8'h20 + 8'(i);
    rst = 1'b1;
    en16 = 1'b0; mode16 = 1'b0; sel16 = 4'd0; mask16 = 16'h0000; ready16 = 1'b1;
    en5 = 1'b0;  mode5 = 1'b0;  sel5 = 3'd0;  mask5 = 5'b00000;  ready5 = 1'b1;
    tick();
    tick();
    chk("reset_Y", 32'(y16), 32'h0);
    chk("reset_ch", 32'(ch16), 32'h0);
    chk("reset_last", 32'(last16), 32'h0);
    chk("reset_valid", 32'(valid16), 32'h0);
    rst = 1'b0;

    // Direct sweep, one sample per cycle
    en16 = 1'b1;
    for (int s = 0; s < 16; s++) begin
      sel16 = 4'(s);
      q16.push_back(mk(8'h10 + 8'(s), 4'(s), 1'b0));
      tick();
      chk("direct_valid", 32'(valid16), 32'h1);
    end
    en16 = 1'b0;
    tick();
    chk("direct_drain_valid", 32'(valid16), 32'h0);

    // Scan with mask 8421; the first cycle after the mode switch does not capture
    mode16 = 1'b1;
    mask16 = 16'h8421;
    tick();
    en16 = 1'b1;
    q16.push_back(mk(8'h10, 4'd0, 1'b0));
    q16.push_back(mk(8'h15, 4'd5, 1'b0));
    q16.push_back(mk(8'h1A, 4'd10, 1'b0));
    q16.push_back(mk(8'h1F, 4'd15, 1'b1));
    q16.push_back(mk(8'h10, 4'd0, 1'b0));
    q16.push_back(mk(8'h15, 4'd5, 1'b0));
    repeat (6) tick();

    // Pointer sits at 6: toggle mode and the sweep restarts at channel 0
    toggle_mode16();
    en16 = 1'b1;
    q16.push_back(mk(8'h10, 4'd0, 1'b0));
    tick();
    en16 = 1'b0;
    tick();

    // Back-pressure with mask 000F
    toggle_mode16();
    mask16 = 16'h000F;
    en16 = 1'b1;
    q16.push_back(mk(8'h10, 4'd0, 1'b0));
    tick();
    ready16 = 1'b0;
    q16.push_back(mk(8'h11, 4'd1, 1'b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_Y", 32'(y16), 32'h10);
      chk("bp_hold_ch", 32'(ch16), 32'h0);
      chk("bp_hold_valid", 32'(valid16), 32'h1);
    end
    ready16 = 1'b1;
    tick();
    chk("bp_next_ch", 32'(ch16), 32'h1);
    en16 = 1'b0;
    tick();

    // Empty mask: nothing captured
    mask16 = 16'h0000;
    en16 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("empty_mask_valid", 32'(valid16), 32'h0);
    end
    mask16 = 16'h0010;
    for (int k = 0; k < 4; k++) q16.push_back(mk(8'h14, 4'd4, 1'b1));
    repeat (4) tick();
    en16 = 1'b0;
    tick();
    chk("enable_drop_valid", 32'(valid16), 32'h0);

    // Reset discards a pending sample
    en16 = 1'b1;
    ready16 = 1'b0;
    tick();
    chk("pre_reset_valid", 32'(valid16), 32'h1);
    rst = 1'b1;
    tick();
    chk("mid_reset_Y", 32'(y16), 32'h0);
    chk("mid_reset_ch", 32'(ch16), 32'h0);
    chk("mid_reset_last", 32'(last16), 32'h0);
    chk("mid_reset_valid", 32'(valid16), 32'h0);
    rst = 1'b0;
    en16 = 1'b0;
    ready16 = 1'b1;
    tick();

    // Five channels: out-of-range select, then scan with wrap at the top channel
    en5 = 1'b1;
    sel5 = 3'd7;
    q5.push_back(mk(8'h00, 4'd7, 1'b0));
    tick();
    sel5 = 3'd2;
    q5.push_back(mk(8'h22, 4'd2, 1'b0));
    tick();
    en5 = 1'b0;
    tick();
    mode5 = 1'b1;
    mask5 = 5'b10011;
    tick();
    en5 = 1'b1;
    q5.push_back(mk(8'h20, 4'd0, 1'b0));
    q5.push_back(mk(8'h21, 4'd1, 1'b0));
    q5.push_back(mk(8'h24, 4'd4, 1'b1));
    q5.push_back(mk(8'h20, 4'd0, 1'b0));
    repeat (4) tick();
    en5 = 1'b0;
    tick();
    tick();

    chk("q16_drained", 32'(q16.size()), 32'h0);
    chk("q5_drained", 32'(q5.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
